// File: rtl/sprite_lunge_animator.sv
// sprite_lunge_animator
//   Battle-screen "quick attack" animator. On start it latches the sprite
//   home position and direction, then moves the sprite out by DIST pixels and
//   back again, one STEP per internal frame tick. One start runs REPEAT
//   lunges, followed by a single done pulse.
//
//   Optional build macro SPRITE_LUNGE_HOP_EN: adds a vertical hop, with
//   pos_y = base_y - (offset >> 2). When it is undefined pos_y is the
//   latched base_y and no hop logic is built.
//
// Ports
//   clock        system clock, rising edge
//   reset        synchronous, active-low
//   start        lunge request, accepted only in IDLE
//   abort        in OUT/BACK: snap the sprite home and finish
//   dir          0 = lunge left (-X), 1 = lunge right (+X), sampled at accept
//   base_x/y     home position, sampled at accept
//   pos_x/y      current sprite position (registered)
//   busy         high from the cycle after accept until done
//   frame_pulse  one-cycle redraw request, aligned with a new position
//   done         one-cycle completion pulse
module sprite_lunge_animator #(
  parameter int X_W       = 9,
  parameter int Y_W       = 8,
  parameter int DIST      = 25,
  parameter int STEP      = 1,
  parameter int REPEAT    = 1,
  parameter int FRAME_DIV = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic           abort,
  input  logic           dir,
  input  logic [X_W-1:0] base_x,
  input  logic [Y_W-1:0] base_y,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic           busy,
  output logic           frame_pulse,
  output logic           done
);

  localparam int OFF_W = $clog2(DIST + 1);
  localparam int CNT_W = $clog2(REPEAT) + 1;
  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  // Sum is one bit wider so offset+STEP can never wrap before the clamp.
  localparam logic [OFF_W:0]   DIST_EXT = (OFF_W + 1)'(DIST);
  localparam logic [OFF_W:0]   STEP_EXT = (OFF_W + 1)'(STEP);
  localparam logic [OFF_W-1:0] DIST_OFF = OFF_W'(DIST);
  localparam logic [OFF_W-1:0] STEP_OFF = OFF_W'(STEP);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPEAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OUT  = 2'd1,
    ST_BACK = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           state_r, state_next_s;
  logic [OFF_W-1:0] offset_r, offset_next_s;
  logic [DIV_W-1:0] div_r, div_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic [X_W-1:0]   base_x_r, base_x_next_s;
  logic [Y_W-1:0]   base_y_r, base_y_next_s;
  logic             dir_r, dir_next_s;

  logic             tick_s;
  logic [OFF_W:0]   sum_s;
  logic [OFF_W-1:0] out_off_s;
  logic [OFF_W-1:0] back_off_s;
  logic             pulse_next_s;
  logic             busy_next_s;
  logic             done_next_s;
  logic [X_W-1:0]   pos_x_next_s;
  logic [Y_W-1:0]   pos_y_next_s;

  logic [X_W-1:0]   pos_x_r;
  logic [Y_W-1:0]   pos_y_r;
  logic             busy_r;
  logic             frame_pulse_r;
  logic             done_r;

  // Next-state, datapath and next-output decode.
  always_comb begin
    state_next_s  = state_r;
    offset_next_s = offset_r;
    div_next_s    = div_r;
    cnt_next_s    = cnt_r;
    base_x_next_s = base_x_r;
    base_y_next_s = base_y_r;
    dir_next_s    = dir_r;
    pulse_next_s  = 1'b0;

    tick_s = (div_r == DIV_LAST);
    sum_s  = {1'b0, offset_r} + STEP_EXT;

    // Saturating step toward DIST (outbound) or toward 0 (return).
    if (sum_s >= DIST_EXT) begin
      out_off_s = DIST_OFF;
    end else begin
      out_off_s = sum_s[OFF_W-1:0];
    end
    if (offset_r <= STEP_OFF) begin
      back_off_s = '0;
    end else begin
      back_off_s = offset_r - STEP_OFF;
    end

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          base_x_next_s = base_x;
          base_y_next_s = base_y;
          dir_next_s    = dir;
          offset_next_s = '0;
          div_next_s    = '0;
          cnt_next_s    = '0;
          state_next_s  = ST_OUT;
        end else begin
          state_next_s  = ST_IDLE;
        end
      end
      ST_OUT: begin
        if (abort) begin
          offset_next_s = '0;
          pulse_next_s  = 1'b1;
          state_next_s  = ST_DONE;
        end else if (tick_s) begin
          div_next_s    = '0;
          offset_next_s = out_off_s;
          pulse_next_s  = 1'b1;
          if (out_off_s == DIST_OFF) begin
            state_next_s = ST_BACK;
          end else begin
            state_next_s = ST_OUT;
          end
        end else begin
          div_next_s = div_r + DIV_W'(1);
        end
      end
      ST_BACK: begin
        if (abort) begin
          offset_next_s = '0;
          pulse_next_s  = 1'b1;
          state_next_s  = ST_DONE;
        end else if (tick_s) begin
          div_next_s    = '0;
          offset_next_s = back_off_s;
          pulse_next_s  = 1'b1;
          if (back_off_s != '0) begin
            state_next_s = ST_BACK;
          end else if (cnt_r == CNT_LAST) begin
            state_next_s = ST_DONE;
          end else begin
            cnt_next_s   = cnt_r + CNT_W'(1);
            state_next_s = ST_OUT;
          end
        end else begin
          div_next_s = div_r + DIV_W'(1);
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase

    // DONE is a one-cycle settle with the home position shown; done is
    // raised as it exits, in the same cycle busy drops.
    busy_next_s = (state_next_s == ST_OUT) || (state_next_s == ST_BACK) ||
                  (state_next_s == ST_DONE);
    done_next_s = (state_r == ST_DONE);

    if (dir_next_s) begin
      pos_x_next_s = base_x_next_s + X_W'(offset_next_s);
    end else begin
      pos_x_next_s = base_x_next_s - X_W'(offset_next_s);
    end

`ifdef SPRITE_LUNGE_HOP_EN
    pos_y_next_s = base_y_next_s - Y_W'(offset_next_s >> 2'd2);
`else
    pos_y_next_s = base_y_next_s;
`endif
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      offset_r      <= '0;
      div_r         <= '0;
      cnt_r         <= '0;
      base_x_r      <= '0;
      base_y_r      <= '0;
      dir_r         <= 1'b0;
      pos_x_r       <= '0;
      pos_y_r       <= '0;
      busy_r        <= 1'b0;
      frame_pulse_r <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      offset_r      <= offset_next_s;
      div_r         <= div_next_s;
      cnt_r         <= cnt_next_s;
      base_x_r      <= base_x_next_s;
      base_y_r      <= base_y_next_s;
      dir_r         <= dir_next_s;
      pos_x_r       <= pos_x_next_s;
      pos_y_r       <= pos_y_next_s;
      busy_r        <= busy_next_s;
      frame_pulse_r <= pulse_next_s;
      done_r        <= done_next_s;
    end
  end

  assign pos_x       = pos_x_r;
  assign pos_y       = pos_y_r;
  assign busy        = busy_r;
  assign frame_pulse = frame_pulse_r;
  assign done        = done_r;

endmodule

// File: tb/tb_sprite_lunge_animator.sv
// Directed bench for sprite_lunge_animator. Instance a uses the default
// parameters; instance b uses STEP=4, REPEAT=3. Expected positions come from
// the tick index: tick t lands on edge 4t after accept.
module tb_sprite_lunge_animator;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic       abort = 1'b0;
  logic       dir = 1'b0;
  logic [8:0] base_x = 9'd0;
  logic [7:0] base_y = 8'd0;

  logic [8:0] pos_x_a, pos_x_b;
  logic [7:0] pos_y_a, pos_y_b;
  logic       busy_a, busy_b, fp_a, fp_b, done_a, done_b;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  sprite_lunge_animator dut_a (
    .clock(clock), .reset(reset), .start(start_a), .abort(abort), .dir(dir),
    .base_x(base_x), .base_y(base_y), .pos_x(pos_x_a), .pos_y(pos_y_a),
    .busy(busy_a), .frame_pulse(fp_a), .done(done_a)
  );

  sprite_lunge_animator #(.STEP(4), .REPEAT(3)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .abort(abort), .dir(dir),
    .base_x(base_x), .base_y(base_y), .pos_x(pos_x_b), .pos_y(pos_y_b),
    .busy(busy_b), .frame_pulse(fp_b), .done(done_b)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] exp_y(input logic [7:0] by, input int off);
`ifdef SPRITE_LUNGE_HOP_EN
    exp_y = by - 8'(off / 4);
`else
    exp_y = by + 8'(off * 0);
`endif
  endfunction

  // One full default lunge (DIST=25, STEP=1, FRAME_DIV=4), checked every cycle.
  task automatic run_a(input logic [8:0] bx, input logic d, input logic [7:0] by);
    int pulses;
    int off;
    logic [8:0] ex;
    base_x = bx; dir = d; base_y = by; start_a = 1'b1;
    step();
    start_a = 1'b0;
    check_val("a_accept_busy", 32'(busy_a), 32'd1);
    check_val("a_accept_pos_x", 32'(pos_x_a), 32'(bx));
    pulses = 0;
    for (int k = 1; k <= 201; k++) begin
      step();
      if (k <= 200) begin
        off = (k / 4 <= 25) ? (k / 4) : (50 - k / 4);
      end else begin
        off = 0;
      end
      ex = d ? (bx + 9'(off)) : (bx - 9'(off));
      check_val("a_pos_x", 32'(pos_x_a), 32'(ex));
      check_val("a_pos_y", 32'(pos_y_a), 32'(exp_y(by, off)));
      check_val("a_frame_pulse", 32'(fp_a), 32'((k % 4 == 0) && (k <= 200)));
      check_val("a_busy", 32'(busy_a), 32'(k <= 200));
      check_val("a_done", 32'(done_a), 32'(k == 201));
      if (fp_a) pulses++;
    end
    step();
    check_val("a_done_one_cycle", 32'(done_a), 32'd0);
    check_val("a_idle_busy", 32'(busy_a), 32'd0);
    check_val("a_pulse_count", 32'(pulses), 32'd50);
  endtask

  int tab_b [14] = '{4, 8, 12, 16, 20, 24, 25, 21, 17, 13, 9, 5, 1, 0};

  initial begin
    int pulses;
    int dones;
    int max_x;
    int off;
    int bad;

    // Reset state
    step();
    step();
    check_val("rst_pos_x", 32'(pos_x_a), 32'd0);
    check_val("rst_pos_y", 32'(pos_y_a), 32'd0);
    check_val("rst_busy", 32'(busy_a), 32'd0);
    check_val("rst_frame_pulse", 32'(fp_a), 32'd0);
    check_val("rst_done", 32'(done_a), 32'd0);
    check_val("rst_busy_b", 32'(busy_b), 32'd0);
    reset = 1'b1;
    step();

    // Abort while idle is ignored
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_val("idle_abort_busy", 32'(busy_a), 32'd0);
    check_val("idle_abort_fp", 32'(fp_a), 32'd0);
    step();
    check_val("idle_abort_done", 32'(done_a), 32'd0);

    // Default lunge left, wrap through zero, lunge right across the top
    run_a(9'd188, 1'b0, 8'd54);
    run_a(9'd10, 1'b0, 8'd54);
    run_a(9'd500, 1'b1, 8'd3);

    // Abort at offset 10, with a start held during DONE that must be ignored
    base_x = 9'd188; dir = 1'b0; base_y = 8'd54; start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int k = 1; k <= 40; k++) step();
    check_val("abort_pre_pos_x", 32'(pos_x_a), 32'd178);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_val("abort_pos_x", 32'(pos_x_a), 32'd188);
    check_val("abort_fp", 32'(fp_a), 32'd1);
    check_val("abort_busy", 32'(busy_a), 32'd1);
    check_val("abort_done_early", 32'(done_a), 32'd0);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check_val("abort_done", 32'(done_a), 32'd1);
    check_val("abort_done_busy", 32'(busy_a), 32'd0);
    check_val("abort_done_fp", 32'(fp_a), 32'd0);
    step();
    check_val("abort_after_done", 32'(done_a), 32'd0);
    check_val("done_start_ignored", 32'(busy_a), 32'd0);

    // Reset in the middle of the return leg
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int k = 1; k <= 120; k++) step();
    check_val("mid_back_pos_x", 32'(pos_x_a), 32'd168);
    reset = 1'b0;
    step();
    check_val("midrst_pos_x", 32'(pos_x_a), 32'd0);
    check_val("midrst_pos_y", 32'(pos_y_a), 32'd0);
    check_val("midrst_busy", 32'(busy_a), 32'd0);
    check_val("midrst_done", 32'(done_a), 32'd0);
    check_val("midrst_fp", 32'(fp_a), 32'd0);
    reset = 1'b1;
    step();
    run_a(9'd188, 1'b0, 8'd54);

    // STEP=4, REPEAT=3, dir right; a start pulse mid-run must be ignored
    base_x = 9'd100; dir = 1'b1; base_y = 8'd54; start_b = 1'b1;
    step();
    start_b = 1'b0;
    check_val("b_accept_busy", 32'(busy_b), 32'd1);
    check_val("b_accept_pos_x", 32'(pos_x_b), 32'd100);
    pulses = 0; dones = 0; max_x = 0;
    for (int k = 1; k <= 169; k++) begin
      step();
      start_b = (k == 49);
      if (k <= 168 && k / 4 > 0) begin
        off = tab_b[(k / 4 - 1) % 14];
      end else begin
        off = 0;
      end
      check_val("b_pos_x", 32'(pos_x_b), 32'(100 + off));
      check_val("b_frame_pulse", 32'(fp_b), 32'((k % 4 == 0) && (k <= 168)));
      check_val("b_busy", 32'(busy_b), 32'(k <= 168));
      check_val("b_done", 32'(done_b), 32'(k == 169));
      if (fp_b) pulses++;
      if (done_b) dones++;
      if (int'(pos_x_b) > max_x) max_x = int'(pos_x_b);
    end
    start_b = 1'b0;
    check_val("b_peak_pos_x", 32'(max_x), 32'd125);
    check_val("b_pulse_count", 32'(pulses), 32'd42);
    check_val("b_end_pos_x", 32'(pos_x_b), 32'd100);
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (busy_b || done_b || fp_b) bad++;
      if (done_b) dones++;
    end
    check_val("b_no_second_run", 32'(bad), 32'd0);
    check_val("b_done_count", 32'(dones), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
